// File: rtl/fetch_predict.sv
// Instruction-fetch stage: fetch PC generation, direct-mapped BTB with 2-bit
// saturating counters for zero-bubble next-PC prediction, and the IF/ID register.
module fetch_predict #(
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic [18:0] ifid_ctrl_o,
  output logic        ifid_pred_taken_o,
  output logic [31:0] ifid_pred_target_o,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_mispredict_i,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);
  localparam int          N     = 1 << IDX_W;
  localparam int          TAG_W = 30 - IDX_W;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [N-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [N];
  logic [TAG_W-1:0] tag_d    [N];
  logic [31:0]      target_q [N];
  logic [31:0]      target_d [N];
  logic [1:0]       ctr_q    [N];
  logic [1:0]       ctr_d    [N];

  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_pred_taken_q, ifid_pred_taken_d;
  logic [31:0] ifid_pred_target_q, ifid_pred_target_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic             f_hit, u_hit, pred_taken, redirect;
  logic [31:0]      next_pc;

  // Lookup reads only registered state, so same-cycle updates are not visible here
  always_comb begin
    f_idx      = pc_q[IDX_W+1:2];
    f_hit      = valid_q[f_idx] && (tag_q[f_idx] == pc_q[31:IDX_W+2]);
    pred_taken = f_hit && ctr_q[f_idx][1];
    next_pc    = pred_taken ? target_q[f_idx] : pc_q + 32'd4;
  end

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    u_idx         = ex_pc_i[IDX_W+1:2];
    u_hit         = valid_q[u_idx] && (tag_q[u_idx] == ex_pc_i[31:IDX_W+2]);
    if (ex_valid_i) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (ex_mispredict_i) mispred_cnt_d = mispred_cnt_q + 32'd1;
      if (u_hit) begin
        if (ex_taken_i) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
          target_d[u_idx] = ex_target_i;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
        end
      end else if (ex_taken_i) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = ex_pc_i[31:IDX_W+2];
        target_d[u_idx] = ex_target_i;
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  // Redirect beats stall; stall freezes the fetch side but not the BTB/counters
  always_comb begin
    redirect           = ex_valid_i && ex_mispredict_i;
    pc_d               = pc_q;
    ifid_valid_d       = ifid_valid_q;
    ifid_pc_d          = ifid_pc_q;
    ifid_instr_d       = ifid_instr_q;
    ifid_pred_taken_d  = ifid_pred_taken_q;
    ifid_pred_target_d = ifid_pred_target_q;
    if (redirect) begin
      pc_d              = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
      ifid_valid_d      = 1'b0;
      ifid_instr_d      = NOP;
      ifid_pred_taken_d = 1'b0;
    end else if (!stall_i) begin
      pc_d               = next_pc;
      ifid_valid_d       = 1'b1;
      ifid_pc_d          = pc_q;
      ifid_instr_d       = instr_i;
      ifid_pred_taken_d  = pred_taken;
      ifid_pred_target_d = next_pc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q            <= '0;
      pc_q               <= RESET_PC;
      ifid_valid_q       <= 1'b0;
      ifid_pc_q          <= 32'd0;
      ifid_instr_q       <= NOP;
      ifid_pred_taken_q  <= 1'b0;
      ifid_pred_target_q <= 32'd0;
      branch_cnt_q       <= 32'd0;
      mispred_cnt_q      <= 32'd0;
    end else begin
      valid_q            <= valid_d;
      pc_q               <= pc_d;
      ifid_valid_q       <= ifid_valid_d;
      ifid_pc_q          <= ifid_pc_d;
      ifid_instr_q       <= ifid_instr_d;
      ifid_pred_taken_q  <= ifid_pred_taken_d;
      ifid_pred_target_q <= ifid_pred_target_d;
      branch_cnt_q       <= branch_cnt_d;
      mispred_cnt_q      <= mispred_cnt_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk_i) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

  assign pc_o               = pc_q;
  assign ifid_valid_o       = ifid_valid_q;
  assign ifid_pc_o          = ifid_pc_q;
  assign ifid_instr_o       = ifid_instr_q;
  assign ifid_ctrl_o        = {ifid_instr_q[30], ifid_instr_q[24:20], ifid_instr_q[19:15],
                               ifid_instr_q[14:12], ifid_instr_q[6:2]};
  assign ifid_pred_taken_o  = ifid_pred_taken_q;
  assign ifid_pred_target_o = ifid_pred_target_q;
  assign branch_cnt_o       = branch_cnt_q;
  assign mispred_cnt_o      = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_predict.sv
// Bench for fetch_predict: directed vector table, counter wrap, async reset,
// then randomized traffic against a behavioural BTB/fetch model.
module tb_fetch_predict;
  localparam int          IDX  = 4;
  localparam int          NE   = 1 << IDX;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        stall = 1'b0, ex_valid = 1'b0, ex_taken = 1'b0, ex_mis = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0;
  logic [31:0] pc_o, instr_i, ifid_pc, ifid_instr, ifid_ptgt, bcnt, mcnt;
  logic [18:0] ifid_ctrl;
  logic        ifid_valid, ifid_pt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign instr_i = imem(pc_o);

  fetch_predict #(.IDX_W(IDX), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .pc_o(pc_o), .instr_i(instr_i),
    .ifid_valid_o(ifid_valid), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
    .ifid_ctrl_o(ifid_ctrl), .ifid_pred_taken_o(ifid_pt), .ifid_pred_target_o(ifid_ptgt),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_taken_i(ex_taken), .ex_target_i(ex_target),
    .ex_mispredict_i(ex_mis), .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
  );

  // Behavioural model: each BTB slot remembers the full PC that owns it
  bit          m_v   [NE];
  logic [31:0] m_own [NE];
  logic [31:0] m_tgt [NE];
  int          m_ctr [NE];
  logic [31:0] m_pc, m_ifpc, m_ifinstr, m_ptgt, m_bc, m_mc;
  bit          m_ifv, m_pt;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % NE);
  endfunction

  function automatic bit owns(input int s, input logic [31:0] a);
    return m_v[s] && ((m_own[s] >> (IDX + 2)) == (a >> (IDX + 2)));
  endfunction

  function automatic logic [18:0] ctrl_of(input logic [31:0] i);
    return {i[30], i[24:20], i[19:15], i[14:12], i[6:2]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) m_v[i] = 0;
    m_pc = 32'h0; m_ifpc = 0; m_ifinstr = NOP; m_ptgt = 0; m_bc = 0; m_mc = 0;
    m_ifv = 0; m_pt = 0;
  endtask

  task automatic model_step();
    int          fs, us;
    bit          pt;
    logic [31:0] npc;
    fs  = slot(m_pc);
    pt  = owns(fs, m_pc) && (m_ctr[fs] >= 2);
    npc = pt ? m_tgt[fs] : m_pc + 32'd4;
    if (ex_valid) begin
      us = slot(ex_pc);
      if (owns(us, ex_pc)) begin
        if (ex_taken) begin
          m_ctr[us] = (m_ctr[us] < 3) ? m_ctr[us] + 1 : 3;
          m_tgt[us] = ex_target;
        end else begin
          m_ctr[us] = (m_ctr[us] > 0) ? m_ctr[us] - 1 : 0;
        end
      end else if (ex_taken) begin
        m_v[us] = 1; m_own[us] = ex_pc; m_tgt[us] = ex_target; m_ctr[us] = 2;
      end
      m_bc = m_bc + 1;
      if (ex_mis) m_mc = m_mc + 1;
    end
    if (ex_valid && ex_mis) begin
      m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      m_ifv = 0; m_ifinstr = NOP; m_pt = 0;
    end else if (!stall) begin
      m_ifpc = m_pc; m_ifinstr = imem(m_pc); m_ifv = 1; m_pt = pt; m_ptgt = npc;
      m_pc = npc;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("pc_o", pc_o, m_pc);
    chk("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
    chk("ifid_instr", ifid_instr, m_ifinstr);
    chk("ifid_ctrl", 32'(ifid_ctrl), 32'(ctrl_of(m_ifinstr)));
    chk("ifid_pred_taken", 32'(ifid_pt), 32'(m_pt));
    if (m_ifv) begin
      chk("ifid_pc", ifid_pc, m_ifpc);
      chk("ifid_pred_target", ifid_ptgt, m_ptgt);
    end
    chk("branch_cnt", bcnt, m_bc);
    chk("mispred_cnt", mcnt, m_mc);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit          stall;
    bit          exv;
    logic [31:0] expc;
    bit          ext;
    logic [31:0] extgt;
    bit          exmis;
    logic [31:0] e_pc;
    bit          e_ifv;
    bit          e_pt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit s, bit e, logic [31:0] p, bit t, logic [31:0] g, bit m,
                             logic [31:0] epc, bit eifv, bit ept);
    vec_t r;
    r.stall = s; r.exv = e; r.expc = p; r.ext = t; r.extgt = g; r.exmis = m;
    r.e_pc = epc; r.e_ifv = eifv; r.e_pt = ept;
    return r;
  endfunction

  initial begin
    // sequential fetch, cold taken branch, stall, stall+redirect, saturation, aliasing
    tbl.push_back(v(0,0,0,0,0,0,          32'h04,1,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h08,1,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h0C,1,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h10,1,0));
    tbl.push_back(v(0,1,32'h10,1,32'h40,1,32'h40,0,0));
    tbl.push_back(v(0,1,32'h0C,1,32'h10,1,32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h40,1,1));
    tbl.push_back(v(1,0,0,0,0,0,          32'h40,1,1));
    tbl.push_back(v(1,0,0,0,0,0,          32'h40,1,1));
    tbl.push_back(v(1,0,0,0,0,0,          32'h40,1,1));
    tbl.push_back(v(1,1,32'h40,1,32'h80,1,32'h80,0,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h84,1,0));
    tbl.push_back(v(0,1,32'h10,1,32'h40,0,32'h88,1,0));
    tbl.push_back(v(0,1,32'h10,1,32'h40,0,32'h8C,1,0));
    tbl.push_back(v(0,1,32'h10,1,32'h40,0,32'h90,1,0));
    tbl.push_back(v(0,1,32'h10,0,32'h00,0,32'h94,1,0));
    tbl.push_back(v(0,1,32'h0C,1,32'h10,1,32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h40,1,1));
    tbl.push_back(v(0,1,32'h10,0,32'h00,1,32'h14,0,0));
    tbl.push_back(v(0,1,32'h0C,1,32'h10,1,32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h14,1,0));
    tbl.push_back(v(0,1,32'h10,1,32'h40,0,32'h18,1,0));
    tbl.push_back(v(0,1,32'h4C,1,32'h50,1,32'h50,0,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h54,1,0));
    tbl.push_back(v(0,1,32'h50,1,32'h60,1,32'h60,0,0));
    tbl.push_back(v(0,1,32'h0C,1,32'h10,1,32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h14,1,0));
    tbl.push_back(v(0,0,0,0,0,0,          32'h18,1,0));

    m_reset();
    #12;
    chk("rst pc_o", pc_o, 32'h0);
    chk("rst ifid_valid", 32'(ifid_valid), 32'd0);
    chk("rst ifid_instr", ifid_instr, NOP);
    chk("rst ifid_ctrl", 32'(ifid_ctrl), 32'h0000_0004);
    chk("rst ifid_pc", ifid_pc, 32'h0);
    chk("rst pred_taken", 32'(ifid_pt), 32'd0);
    chk("rst pred_target", ifid_ptgt, 32'h0);
    chk("rst branch_cnt", bcnt, 32'h0);
    chk("rst mispred_cnt", mcnt, 32'h0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      stall = tbl[k].stall; ex_valid = tbl[k].exv; ex_pc = tbl[k].expc;
      ex_taken = tbl[k].ext; ex_target = tbl[k].extgt; ex_mis = tbl[k].exmis;
      cycle();
      chk($sformatf("vec%0d pc_o", k), pc_o, tbl[k].e_pc);
      chk($sformatf("vec%0d ifid_valid", k), 32'(ifid_valid), 32'(tbl[k].e_ifv));
      chk($sformatf("vec%0d pred_taken", k), 32'(ifid_pt), 32'(tbl[k].e_pt));
    end
    chk("tbl branch_cnt", bcnt, 32'd14);
    chk("tbl mispred_cnt", mcnt, 32'd9);

    // counter wrap at 2^32
    force dut.branch_cnt_q  = 32'hFFFF_FFFF;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    m_bc = 32'hFFFF_FFFF; m_mc = 32'hFFFF_FFFF;
    stall = 0; ex_valid = 1; ex_pc = 32'h20; ex_taken = 0; ex_target = 0; ex_mis = 1;
    cycle();
    chk("wrap branch_cnt", bcnt, 32'h0);
    chk("wrap mispred_cnt", mcnt, 32'h0);
    ex_valid = 0; ex_mis = 0;
    repeat (3) cycle();

    // asynchronous reset in the middle of a cycle
    #2 rst = 1'b1;
    #1;
    chk("async rst pc_o", pc_o, 32'h0);
    chk("async rst ifid_valid", 32'(ifid_valid), 32'd0);
    chk("async rst branch_cnt", bcnt, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post rst pc_o", pc_o, 32'h4);
    // a previously learned branch at 0x10 must be gone
    repeat (4) cycle();
    chk("post rst no predict", 32'(ifid_pt), 32'd0);

    for (int n = 0; n < 800; n++) begin
      stall     = ($urandom_range(0, 99) < 20);
      ex_valid  = ($urandom_range(0, 99) < 40);
      ex_pc     = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      ex_taken  = ($urandom_range(0, 99) < 60);
      ex_target = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      ex_mis    = ($urandom_range(0, 99) < 30);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_predict.md
# fetch_predict

Instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It sits directly upstream of the decode/hazard control stage. It generates the fetch PC, predicts next-PC with zero bubbles, and registers the IF/ID pipeline word, including the 19-bit control field decode consumes. It honours decode's stall request and EX-stage branch resolution and redirect.

## Interface
- IDX_W, 4, BTB index width; the BTB has 2^IDX_W entries.
- RESET_PC, 32'h0000_0000, fetch address after reset.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold request from decode hazard unit (its nop output)
- pc_o  out  32  current fetch address to instruction memory
- instr_i  in  32  instruction at pc_o, combinational memory read, same cycle
- ifid_valid_o  out  1  IF/ID holds a real instruction
- ifid_pc_o  out  32  PC of IF/ID instruction
- ifid_instr_o  out  32  IF/ID instruction
- ifid_ctrl_o  out  19  {instr[30], instr[24:20], instr[19:15], instr[14:12], instr[6:2]} of ifid_instr_o, combinational
- ifid_pred_taken_o  out  1  fetch predicted taken
- ifid_pred_target_o  out  32  predicted next PC used at fetch
- ex_valid_i  in  1  EX holds a resolved control-flow instruction
- ex_pc_i  in  32  its PC
- ex_taken_i  in  1  actual direction (jumps always 1)
- ex_target_i  in  32  actual taken target
- ex_mispredict_i  in  1  EX detected a wrong predicted next-PC
- branch_cnt_o  out  32  resolved branches/jumps, wraps
- mispred_cnt_o  out  32  mispredictions, wraps

## Operation
- BTB entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2].
- Lookup on pc_o: hit = valid && tag match. Predict taken iff hit && ctr[1]. next_pc is the entry target when predict taken, else pc_o+4 (mod 2^32).
- Update when ex_valid_i:
  - On a hit at ex_pc_i: ctr saturating +1 if taken, -1 if not. Target is overwritten with ex_target_i when taken.
  - On a miss and taken: allocate or replace the entry: valid=1, tag, target, ctr=2'b10.
  - On a miss and not taken: no change.
- Priority at each edge: rst_i > redirect (ex_valid_i && ex_mispredict_i) > stall_i > normal.
- Redirect:
  - pc_o <= ex_taken_i ? ex_target_i : ex_pc_i+4.
  - IF/ID flushed: ifid_valid_o=0, ifid_instr_o=32'h0000_0013, pred_taken=0.
  - Overrides stall_i.
- Stall, no redirect: pc_o and all ifid_* outputs hold. The BTB update and counters still proceed.
- Normal:
  - pc_o <= next_pc.
  - ifid_pc_o <= pc_o, ifid_instr_o <= instr_i, ifid_valid_o <= 1.
  - ifid_pred_taken_o and ifid_pred_target_o take this cycle's prediction.
- Counters, when ex_valid_i:
  - branch_cnt_o +1.
  - mispred_cnt_o +1 if ex_mispredict_i.
  - Both wrap at 2^32.
- Reset values:
  - pc_o=RESET_PC.
  - All BTB valid=0; target and ctr contents are don't-care.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=32'h0000_0013, ifid_pred_taken_o=0, ifid_pred_target_o=0.
  - Both counters 0.
  - ifid_ctrl_o follows the NOP encoding.

## Timing
- Prediction is zero-bubble: the lookup is combinational on the registered pc_o, and next_pc is registered at the same edge as IF/ID.
- A redirect is applied at the edge where ex_valid_i && ex_mispredict_i is sampled. The corrected fetch address appears on pc_o in the following cycle.
- Lookup and update on the same index in the same cycle: the lookup sees pre-update contents. The update is visible from the next cycle.
- stall_i is sampled at the edge. One stall cycle gives exactly one repeated pc_o/IF/ID cycle.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Fetch resumes at RESET_PC on the first edge after deassertion.

## Test plan
- Reset then release with no branches -> pc_o 0x0, 0x4, 0x8, 0xC on successive cycles. ifid_valid_o goes 0 then 1. ifid_pc_o lags pc_o by one cycle.
- Cold taken branch at 0x10 to 0x40: EX asserts taken + mispredict -> next pc_o=0x40, ifid_valid_o=0. Refetching 0x10 then gives ifid_pred_taken_o=1, ifid_pred_target_o=0x40, and the next pc_o=0x40.
- Saturation at 0x10: three taken updates (ctr=11), then one not-taken -> still predicts 0x40. A second not-taken -> predicts 0x14.
- stall_i high 3 cycles -> pc_o and ifid_* constant. Stall and mispredict (target 0x80) together -> pc_o=0x80 and IF/ID flushed.
- Aliasing, IDX_W=4: entry for 0x10 valid; fetch 0x50 (same index, different tag) -> no prediction, pc_o+4. A taken resolve at 0x50 replaces the entry, after which 0x10 misses.
- Five resolves, two mispredicted -> branch_cnt_o=5, mispred_cnt_o=2. Preload 32'hFFFF_FFFF and resolve once -> wraps to 0.
